alarm_timer: RTL and testbench

- Countdown timer paired with the anti-theft FSM.
- Consumes the FSM's start request and 2-bit interval select.
- Returns a one-cycle expiry pulse that drives the FSM's timer_status input.
- Holds the four programmable delay values and contains the 1 Hz tick divider used by the whole alarm.

---
 rtl/alarm_timer_pkg.sv | 21 ++
 rtl/one_hz_divider.sv | 28 ++
 rtl/alarm_timer.sv | 121 ++++++++++++
 tb/tb_alarm_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_timer_pkg.sv
// Shared encodings and default delays for the alarm countdown timer.
package alarm_timer_pkg;

  localparam logic [1:0] IV_ARM       = 2'b00;
  localparam logic [1:0] IV_DRIVER    = 2'b01;
  localparam logic [1:0] IV_PASSENGER = 2'b10;
  localparam logic [1:0] IV_ALARM     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_COUNTING = 2'b01,
    ST_EXPIRE   = 2'b10
  } state_t;

  localparam int unsigned CLK_HZ_DEFAULT      = 27000000;
  localparam int unsigned T_ARM_DEFAULT       = 6;
  localparam int unsigned T_DRIVER_DEFAULT    = 8;
  localparam int unsigned T_PASSENGER_DEFAULT = 15;
  localparam int unsigned T_ALARM_DEFAULT     = 10;

endpackage

// File: rtl/one_hz_divider.sv
// Free-running 1 Hz tick divider; restart realigns it so the next second is full length.
module one_hz_divider #(
  parameter int unsigned CLK_HZ = 27000000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_HZ - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || (count == TC)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == TC);

endmodule

// File: rtl/alarm_timer.sv
// Countdown timer for the anti-theft FSM: selectable delays, 1 Hz divider, expiry pulse.
// Define ALARM_TIMER_REPROGRAM_EN to make the four delays writable at run time.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int unsigned T_ARM_DEF       = T_ARM_DEFAULT,
  parameter int unsigned T_DRIVER_DEF    = T_DRIVER_DEFAULT,
  parameter int unsigned T_PASSENGER_DEF = T_PASSENGER_DEFAULT,
  parameter int unsigned T_ALARM_DEF     = T_ALARM_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] prog_sel,
  input  logic [3:0] prog_value,
  output logic       expired,
  output logic [3:0] remaining,
  output logic       busy,
  output logic       one_hz
);

  state_t     state;
  logic [3:0] load_value;
  logic       tick;

  one_hz_divider #(
    .CLK_HZ (CLK_HZ)
  ) u_divider (
    .clock   (clock),
    .reset   (reset),
    .restart (start_timer),
    .tick    (tick)
  );

  assign one_hz = tick;

`ifdef ALARM_TIMER_REPROGRAM_EN
  logic [3:0] delay_q [4];

  // A same-edge start reads the pre-write value because the write lands on that edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      delay_q[IV_ARM]       <= 4'(T_ARM_DEF);
      delay_q[IV_DRIVER]    <= 4'(T_DRIVER_DEF);
      delay_q[IV_PASSENGER] <= 4'(T_PASSENGER_DEF);
      delay_q[IV_ALARM]     <= 4'(T_ALARM_DEF);
    end else if (reprogram) begin
      delay_q[prog_sel] <= prog_value;
    end
  end

  assign load_value = delay_q[interval];
`else
  logic unused_prog;
  assign unused_prog = ^{reprogram, prog_sel, prog_value};

  always_comb begin
    load_value = 4'(T_ARM_DEF);
    case (interval)
      IV_ARM:       load_value = 4'(T_ARM_DEF);
      IV_DRIVER:    load_value = 4'(T_DRIVER_DEF);
      IV_PASSENGER: load_value = 4'(T_PASSENGER_DEF);
      IV_ALARM:     load_value = 4'(T_ALARM_DEF);
      default:      load_value = 4'(T_ARM_DEF);
    endcase
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      expired   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      expired <= 1'b0;
      // A start from any state abandons the current count; its pending tick is ignored.
      if (start_timer) begin
        remaining <= load_value;
        if (load_value != 4'd0) begin
          state <= ST_COUNTING;
          busy  <= 1'b1;
        end else begin
          state   <= ST_EXPIRE;
          busy    <= 1'b0;
          expired <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_COUNTING: begin
            if (tick) begin
              if (remaining <= 4'd1) begin
                remaining <= '0;
                state     <= ST_EXPIRE;
                busy      <= 1'b0;
                expired   <= 1'b1;
              end else begin
                remaining <= remaining - 4'd1;
              end
            end
          end
          ST_EXPIRE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Directed bench for alarm_timer with a 10-cycle second.
module tb_alarm_timer;
  import alarm_timer_pkg::*;

  localparam int unsigned CLK_HZ = 10;
`ifdef ALARM_TIMER_REPROGRAM_EN
  localparam bit REPROG = 1'b1;
`else
  localparam bit REPROG = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_timer = 1'b0;
  logic [1:0] interval = 2'b00;
  logic       reprogram = 1'b0;
  logic [1:0] prog_sel = 2'b00;
  logic [3:0] prog_value = 4'd0;
  logic       expired;
  logic [3:0] remaining;
  logic       busy;
  logic       one_hz;

  int checks = 0;
  int errors = 0;

  alarm_timer #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_timer (start_timer),
    .interval    (interval),
    .reprogram   (reprogram),
    .prog_sel    (prog_sel),
    .prog_value  (prog_value),
    .expired     (expired),
    .remaining   (remaining),
    .busy        (busy),
    .one_hz      (one_hz)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rp;
    logic [1:0] ps;
    logic [3:0] pv;
    logic [1:0] iv;
    int         exp_n;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [1:0] iv, input logic rp, input logic [1:0] ps,
                          input logic [3:0] pv);
    start_timer = 1'b1;
    interval    = iv;
    reprogram   = rp;
    prog_sel    = ps;
    prog_value  = pv;
    step();
    start_timer = 1'b0;
    reprogram   = 1'b0;
  endtask

  task automatic do_prog(input logic [1:0] ps, input logic [3:0] pv);
    reprogram  = 1'b1;
    prog_sel   = ps;
    prog_value = pv;
    step();
    reprogram  = 1'b0;
  endtask

  // Entered just after the start edge; follows the count to its expiry pulse.
  task automatic run_count(input string name, input int n);
    int c;
    c = 0;
    check({name, " busy_after_start"}, int'(busy), (n > 0) ? 1 : 0);
    check({name, " remaining_loaded"}, int'(remaining), n);
    while (!expired && c < 400) begin
      if (c > 0 && (c % CLK_HZ) == 0 && c < n * CLK_HZ)
        check({name, " remaining_step"}, int'(remaining), n - c / CLK_HZ);
      if (c == CLK_HZ - 2)
        check({name, " one_hz_low"}, int'(one_hz), 0);
      if (c == CLK_HZ - 1)
        check({name, " one_hz_tick"}, int'(one_hz), 1);
      step();
      c++;
    end
    check({name, " latency"}, c, n * CLK_HZ);
    check({name, " busy_at_expire"}, int'(busy), 0);
    check({name, " remaining_at_expire"}, int'(remaining), 0);
    step();
    check({name, " pulse_width"}, int'(expired), 0);
  endtask

  task automatic count_stray(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      if (expired) pulses++;
      step();
    end
    check({name, " stray_pulses"}, pulses, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int pulses;

    vecs[0] = '{rp: 1'b0, ps: 2'd0, pv: 4'd0, iv: IV_ARM,       exp_n: 6};
    vecs[1] = '{rp: 1'b1, ps: 2'd1, pv: 4'd3, iv: IV_DRIVER,    exp_n: REPROG ? 3 : 8};
    vecs[2] = '{rp: 1'b1, ps: 2'd2, pv: 4'd0, iv: IV_PASSENGER, exp_n: REPROG ? 0 : 15};
    vecs[3] = '{rp: 1'b0, ps: 2'd0, pv: 4'd0, iv: IV_ALARM,     exp_n: 10};

    repeat (3) step();
    check("reset remaining", int'(remaining), 0);
    check("reset busy", int'(busy), 0);
    check("reset expired", int'(expired), 0);
    check("reset one_hz", int'(one_hz), 0);
    #2 reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].rp) do_prog(vecs[i].ps, vecs[i].pv);
      do_start(vecs[i].iv, 1'b0, 2'd0, 4'd0);
      run_count($sformatf("vec%0d", i), vecs[i].exp_n);
      repeat (2) step();
    end

    // Restart mid-count: the abandoned count must not pulse.
    do_start(IV_ALARM, 1'b0, 2'd0, 4'd0);
    c = 0;
    pulses = 0;
    while (remaining != 4'd4 && c < 200) begin
      if (expired) pulses++;
      step();
      c++;
    end
    check("restart reach_4_cycles", c, 60);
    check("restart early_pulses", pulses, 0);
    do_start(IV_ARM, 1'b0, 2'd0, 4'd0);
    run_count("restart", 6);
    count_stray("restart", 30);

    // Same-edge reprogram and start.
    do_start(IV_ARM, 1'b1, 2'd0, 4'd2);
    run_count("same_edge", 6);
    step();
    do_start(IV_ARM, 1'b0, 2'd0, 4'd0);
    run_count("after_same_edge", REPROG ? 2 : 6);
    step();

    // Asynchronous reset mid-count.
    do_start(IV_ARM, 1'b0, 2'd0, 4'd0);
    c = 0;
    while (remaining != 4'd5 && c < 200) begin
      step();
      c++;
    end
    check("async reach_5_cycles", c, 10);
    check("async busy_before", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    check("async remaining", int'(remaining), 0);
    check("async busy", int'(busy), 0);
    check("async expired", int'(expired), 0);
    check("async one_hz", int'(one_hz), 0);
    #3 reset = 1'b1;
    step();
    count_stray("post_reset", 80);
    do_start(IV_ARM, 1'b0, 2'd0, 4'd0);
    run_count("default_arm", 6);
    step();
    do_start(IV_DRIVER, 1'b0, 2'd0, 4'd0);
    run_count("default_driver", 8);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
